wm8731_cfg_ctrl: RTL and testbench

- Power-up configuration sequencer for the WM8731 codec.
- Walks a fixed register table and drives the existing IIC write engine once per entry; each transaction is one 24-bit word: device address, register address, data.
- Checks the ACK result of every write, retries failed writes, and reports done or error to the top level.
- Sits between the top-level reset/startup logic and the IIC instance that drives SCL/SDA.

---
 rtl/wm8731_pkg.sv | 41 ++++
 rtl/wm8731_cfg_rom.sv | 33 +++
 rtl/wm8731_cfg_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_wm8731_cfg_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wm8731_pkg.sv
// Shared definitions for the WM8731 power-up configuration sequencer:
// codec register map, default register contents and FSM state encoding.
package wm8731_pkg;

    localparam logic [6:0] R0_LLINE  = 7'h00;
    localparam logic [6:0] R1_RLINE  = 7'h01;
    localparam logic [6:0] R2_LHP    = 7'h02;
    localparam logic [6:0] R3_RHP    = 7'h03;
    localparam logic [6:0] R4_APATH  = 7'h04;
    localparam logic [6:0] R5_DPATH  = 7'h05;
    localparam logic [6:0] R6_PWR    = 7'h06;
    localparam logic [6:0] R7_IFACE  = 7'h07;
    localparam logic [6:0] R8_SAMPLE = 7'h08;
    localparam logic [6:0] R9_ACTIVE = 7'h09;
    localparam logic [6:0] R15_RESET = 7'h0F;

    // Line-in and headphone writes set the "both channels" bit, so R1 is not needed.
    localparam logic [8:0] D_RESET  = 9'h000;
    localparam logic [8:0] D_LLINE  = 9'h117;
    localparam logic [8:0] D_RLINE  = 9'h017;
    localparam logic [8:0] D_LHP    = 9'h179;
    localparam logic [8:0] D_RHP    = 9'h079;
    localparam logic [8:0] D_APATH  = 9'h012;
    localparam logic [8:0] D_DPATH  = 9'h000;
    localparam logic [8:0] D_PWR    = 9'h000;
    localparam logic [8:0] D_IFACE  = 9'h002;
    localparam logic [8:0] D_SAMPLE = 9'h000;
    localparam logic [8:0] D_ACTIVE = 9'h001;

    typedef enum logic [2:0] {
        S_PWR   = 3'd0,
        S_LOAD  = 3'd1,
        S_REQ   = 3'd2,
        S_BUSY  = 3'd3,
        S_CHECK = 3'd4,
        S_GAP   = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } cfg_state_e;

endpackage

// File: rtl/wm8731_cfg_rom.sv
// Fixed WM8731 configuration table: entry index in, register address and
// 9-bit data out. Reset comes first and activation last.
module wm8731_cfg_rom
    import wm8731_pkg::*;
(
    input  logic [4:0] index,
    output logic [6:0] reg_addr,
    output logic [8:0] reg_data
);

    // Table lookup; indices past the table fall back to a harmless reset write.
    always_comb begin
        reg_addr = R15_RESET;
        reg_data = D_RESET;
        case (index)
            5'd0: begin reg_addr = R15_RESET; reg_data = D_RESET;  end
            5'd1: begin reg_addr = R0_LLINE;  reg_data = D_LLINE;  end
            5'd2: begin reg_addr = R2_LHP;    reg_data = D_LHP;    end
            5'd3: begin reg_addr = R3_RHP;    reg_data = D_RHP;    end
            5'd4: begin reg_addr = R4_APATH;  reg_data = D_APATH;  end
            5'd5: begin reg_addr = R5_DPATH;  reg_data = D_DPATH;  end
            5'd6: begin reg_addr = R6_PWR;    reg_data = D_PWR;    end
            5'd7: begin reg_addr = R7_IFACE;  reg_data = D_IFACE;  end
            5'd8: begin reg_addr = R8_SAMPLE; reg_data = D_SAMPLE; end
            5'd9: begin reg_addr = R9_ACTIVE; reg_data = D_ACTIVE; end
            default: begin
                reg_addr = R15_RESET;
                reg_data = D_RESET;
            end
        endcase
    end

endmodule

// File: rtl/wm8731_cfg_ctrl.sv
// WM8731 power-up configuration sequencer: walks the register table, drives
// one IIC write per entry, retries NACKed writes and reports done or error.
module wm8731_cfg_ctrl
    import wm8731_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR  = 8'h34,
    parameter int         REG_NUM   = 10,
    parameter int         PWR_DLY   = 1_000_000,
    parameter int         GAP_DLY   = 500,
    parameter int         MAX_RETRY = 3,
    parameter int         TIMEOUT   = 20_000
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        cfg_start,
    input  logic        iic_idle,
    input  logic        iic_ack_n,
    output logic [23:0] iic_data,
    output logic        iic_start,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [4:0]  cfg_index
);

    localparam int DLY_MAX = (PWR_DLY > GAP_DLY) ? PWR_DLY : GAP_DLY;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);
    localparam int TO_W    = $clog2(TIMEOUT + 1);
    localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [DLY_W-1:0] PWR_LAST = DLY_W'(PWR_DLY - 1);
    localparam logic [DLY_W-1:0] GAP_LAST = DLY_W'(GAP_DLY - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [4:0]       IDX_LAST = 5'(REG_NUM - 1);

    cfg_state_e       state_q, state_d;
    logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [4:0]       index_q, index_d;
    logic [23:0]      iic_data_q, iic_data_d;
    logic             iic_start_q, iic_start_d;
    logic             cfg_busy_q, cfg_busy_d;
    logic             cfg_done_q, cfg_done_d;
    logic             cfg_err_q, cfg_err_d;
    logic [6:0]       rom_addr_s;
    logic [8:0]       rom_data_s;

    wm8731_cfg_rom u_rom (
        .index    (index_q),
        .reg_addr (rom_addr_s),
        .reg_data (rom_data_s)
    );

    // Next-state logic; counters rest at zero outside the states that use them.
    always_comb begin
        state_d    = state_q;
        dly_cnt_d  = '0;
        to_cnt_d   = '0;
        retry_d    = retry_q;
        index_d    = index_q;
        iic_data_d = iic_data_q;
        case (state_q)
            S_PWR: begin
                if (dly_cnt_q == PWR_LAST) begin
                    state_d = S_LOAD;
                    index_d = 5'd0;
                    retry_d = '0;
                end else begin
                    dly_cnt_d = dly_cnt_q + DLY_W'(1);
                end
            end
            S_LOAD: begin
                iic_data_d = {DEV_ADDR, rom_addr_s, rom_data_s};
                if (iic_idle) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_REQ: begin
                if (to_cnt_q == TO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (!iic_idle) begin
                        state_d = S_BUSY;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_BUSY: begin
                if (to_cnt_q == TO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (iic_idle) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_CHECK: begin
                if (!iic_ack_n) begin
                    retry_d = '0;
                    if (index_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        index_d = index_q + 5'd1;
                        state_d = S_GAP;
                    end
                end else if (retry_q < RTY_MAX) begin
                    retry_d = retry_q + RTY_W'(1);
                    state_d = S_GAP;
                end else begin
                    state_d = S_ERR;
                end
            end
            S_GAP: begin
                if (dly_cnt_q == GAP_LAST) begin
                    state_d = S_LOAD;
                end else begin
                    dly_cnt_d = dly_cnt_q + DLY_W'(1);
                end
            end
            S_DONE, S_ERR: begin
                if (cfg_start) begin
                    state_d = S_PWR;
                    index_d = 5'd0;
                    retry_d = '0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_PWR;
            end
        endcase
    end

    // Outputs decoded from the next state so they register in step with it.
    always_comb begin
        iic_start_d = (state_d == S_REQ);
        cfg_done_d  = (state_d == S_DONE);
        cfg_err_d   = (state_d == S_ERR);
        cfg_busy_d  = (state_d != S_DONE) && (state_d != S_ERR);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q     <= S_PWR;
            dly_cnt_q   <= '0;
            to_cnt_q    <= '0;
            retry_q     <= '0;
            index_q     <= 5'd0;
            iic_data_q  <= 24'h000000;
            iic_start_q <= 1'b0;
            cfg_busy_q  <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dly_cnt_q   <= dly_cnt_d;
            to_cnt_q    <= to_cnt_d;
            retry_q     <= retry_d;
            index_q     <= index_d;
            iic_data_q  <= iic_data_d;
            iic_start_q <= iic_start_d;
            cfg_busy_q  <= cfg_busy_d;
            cfg_done_q  <= cfg_done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign iic_data  = iic_data_q;
    assign iic_start = iic_start_q;
    assign cfg_busy  = cfg_busy_q;
    assign cfg_done  = cfg_done_q;
    assign cfg_err   = cfg_err_q;
    assign cfg_index = index_q;

endmodule

// File: tb/tb_wm8731_cfg_ctrl.sv
// Directed bench for wm8731_cfg_ctrl: a scripted IIC slave model plus a
// scenario table, and hand-written sequences for timeout, reset and re-run.
module tb_wm8731_cfg_ctrl;

    localparam int PWR_DLY   = 100;
    localparam int GAP_DLY   = 10;
    localparam int REG_NUM   = 10;
    localparam int MAX_RETRY = 3;
    localparam int TIMEOUT   = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start;
    logic        iic_idle;
    logic        iic_ack_n;
    logic [23:0] iic_data;
    logic        iic_start;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_err;
    logic [4:0]  cfg_index;

    always #10 clk = ~clk;

    wm8731_cfg_ctrl #(
        .DEV_ADDR  (8'h34),
        .REG_NUM   (REG_NUM),
        .PWR_DLY   (PWR_DLY),
        .GAP_DLY   (GAP_DLY),
        .MAX_RETRY (MAX_RETRY),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_in    (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .iic_idle  (iic_idle),
        .iic_ack_n (iic_ack_n),
        .iic_data  (iic_data),
        .iic_start (iic_start),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .cfg_index (cfg_index)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Slave script, written only by the main initial block.
    int   nack_entry;
    int   nack_times;
    logic nack_forever;
    logic hang;

    // Slave state, written only by the slave process.
    logic        s1, s2;
    int          busy_cnt, entry, nacks, starts;
    logic [23:0] log_q [64];

    logic [23:0] exp_rom [10] = '{24'h341E00, 24'h340117, 24'h340579, 24'h340679, 24'h340812,
                                  24'h340A00, 24'h340C00, 24'h340E02, 24'h341000, 24'h341201};
    logic [23:0] exp_q [$];

    typedef struct {
        int         nack_entry;
        int         nack_times;
        logic       nack_forever;
        logic       hang;
        int         exp_starts;
        logic       exp_done;
        logic       exp_err;
        logic       chk_index;
        logic [4:0] exp_index;
    } vec_t;

    vec_t vecs [4];

    // IIC engine model: 2-flop start synchroniser, 4-cycle busy, scripted ACK_n.
    always @(negedge clk) begin
        if (!rst_n) begin
            iic_idle  <= 1'b1;
            iic_ack_n <= 1'b1;
            s1 <= 1'b0; s2 <= 1'b0;
            busy_cnt <= 0; entry <= 0; nacks <= 0; starts <= 0;
        end else begin
            s1 <= iic_start;
            s2 <= s1;
            if (busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) begin
                    iic_idle <= 1'b1;
                    if (entry == nack_entry && (nack_forever || nacks < nack_times)) begin
                        iic_ack_n <= 1'b1;
                        nacks     <= nacks + 1;
                    end else begin
                        iic_ack_n <= 1'b0;
                        entry     <= entry + 1;
                    end
                end
            end else if (s1 && !s2 && iic_idle) begin
                iic_idle <= 1'b0;
                busy_cnt <= hang ? 0 : 4;
                if (starts < 64) log_q[starts] <= iic_data;
                starts <= starts + 1;
            end
        end
    end

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", what, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk); #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
    endtask

    task automatic wait_end(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (cfg_done || cfg_err) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++; n_bad++;
            $display("FAIL wait_end: no done/err within %0d cycles", budget);
        end
    endtask

    task automatic wait_busy(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (!iic_idle && !iic_start && cfg_busy) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++; n_bad++;
            $display("FAIL wait_busy: no transfer within %0d cycles", budget);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " iic_start"}, {31'd0, iic_start}, 32'd0);
        check({tag, " iic_data"},  {8'd0, iic_data},   32'd0);
        check({tag, " cfg_busy"},  {31'd0, cfg_busy},  32'd0);
        check({tag, " cfg_done"},  {31'd0, cfg_done},  32'd0);
        check({tag, " cfg_err"},   {31'd0, cfg_err},   32'd0);
        check({tag, " cfg_index"}, {27'd0, cfg_index}, 32'd0);
    endtask

    initial begin
        int base;
        int cnt;
        int tries;
        rst_n = 1'b0; cfg_start = 1'b0;
        nack_entry = -1; nack_times = 0; nack_forever = 1'b0; hang = 1'b0;

        vecs[0] = '{-1, 0, 1'b0, 1'b0, 10, 1'b1, 1'b0, 1'b0, 5'd0};
        vecs[1] = '{ 3, 2, 1'b0, 1'b0, 12, 1'b1, 1'b0, 1'b0, 5'd0};
        vecs[2] = '{ 5, 0, 1'b1, 1'b0,  9, 1'b0, 1'b1, 1'b1, 5'd5};
        vecs[3] = '{-1, 0, 1'b0, 1'b1,  1, 1'b0, 1'b1, 1'b1, 5'd0};

        repeat (3) tick();
        check_reset_outputs("reset");

        for (int v = 0; v < 4; v++) begin
            nack_entry   = vecs[v].nack_entry;
            nack_times   = vecs[v].nack_times;
            nack_forever = vecs[v].nack_forever;
            hang         = vecs[v].hang;
            do_reset();
            wait_end(5000);
            check($sformatf("row%0d starts", v), starts, vecs[v].exp_starts);
            check($sformatf("row%0d done", v), {31'd0, cfg_done}, {31'd0, vecs[v].exp_done});
            check($sformatf("row%0d err", v), {31'd0, cfg_err}, {31'd0, vecs[v].exp_err});
            check($sformatf("row%0d busy", v), {31'd0, cfg_busy}, 32'd0);
            check($sformatf("row%0d start", v), {31'd0, iic_start}, 32'd0);
            if (vecs[v].chk_index)
                check($sformatf("row%0d index", v), {27'd0, cfg_index}, {27'd0, vecs[v].exp_index});
            exp_q.delete();
            if (vecs[v].hang) begin
                exp_q.push_back(exp_rom[0]);
            end else begin
                for (int e = 0; e < REG_NUM; e++) begin
                    tries = 1;
                    if (e == vecs[v].nack_entry)
                        tries = vecs[v].nack_forever ? MAX_RETRY + 1 : vecs[v].nack_times + 1;
                    for (int t = 0; t < tries; t++) exp_q.push_back(exp_rom[e]);
                    if (e == vecs[v].nack_entry && vecs[v].nack_forever) break;
                end
            end
            for (int k = 0; k < exp_q.size(); k++)
                check($sformatf("row%0d xfer%0d", v, k), {8'd0, log_q[k]}, {8'd0, exp_q[k]});
            repeat (50) tick();
            check($sformatf("row%0d no more starts", v), starts, vecs[v].exp_starts);
        end

        // Timeout: engine stuck busy, error exactly TIMEOUT cycles after S_REQ entry.
        hang = 1'b1; nack_entry = -1; nack_forever = 1'b0;
        do_reset();
        cnt = 0;
        while (!iic_start && cnt < 500) begin tick(); cnt++; end
        check("timeout start seen", {31'd0, iic_start}, 32'd1);
        cnt = 0;
        while (!cfg_err && cnt < 500) begin tick(); cnt++; end
        check("timeout cycles", cnt, TIMEOUT);
        check("timeout start low", {31'd0, iic_start}, 32'd0);
        check("timeout busy low", {31'd0, cfg_busy}, 32'd0);

        // Reset pulse while entry 4 is in S_BUSY.
        hang = 1'b0;
        do_reset();
        cnt = 0;
        while (!(entry == 4 && !iic_idle && !iic_start) && cnt < 2000) begin tick(); cnt++; end
        check("midreset index", {27'd0, cfg_index}, 32'd4);
        @(negedge clk); #2 rst_n = 1'b0;
        tick();
        check_reset_outputs("midreset");
        @(negedge clk); #2 rst_n = 1'b1;
        cnt = 1;
        tick();
        check("midreset busy", {31'd0, cfg_busy}, 32'd1);
        while (!iic_start && cnt < 500) begin tick(); cnt++; end
        check("midreset restart latency", cnt, PWR_DLY + 1);
        check("midreset restart data", {8'd0, iic_data}, 32'h00341E00);
        wait_end(5000);
        check("midreset done", {31'd0, cfg_done}, 32'd1);
        check("midreset starts", starts, 10);

        // Re-run from S_DONE; a cfg_start pulse mid-transfer must be ignored.
        base = starts;
        @(negedge clk); #2 cfg_start = 1'b1;
        tick();
        check("rerun done drops", {31'd0, cfg_done}, 32'd0);
        check("rerun busy", {31'd0, cfg_busy}, 32'd1);
        @(negedge clk); #2 cfg_start = 1'b0;
        wait_busy(2000);
        @(negedge clk); #2 cfg_start = 1'b1;
        @(negedge clk); #2 cfg_start = 1'b0;
        wait_end(5000);
        check("rerun done", {31'd0, cfg_done}, 32'd1);
        check("rerun err", {31'd0, cfg_err}, 32'd0);
        check("rerun starts", starts - base, 10);
        check("rerun last data", {8'd0, iic_data}, 32'h00341201);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
